exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle control sequencer for the EnDMe processor. Steps each instruction through fetch, execute and data-memory phases, and drives the enable strobes for instruction fetch, the instruction register, accumulator, register file and data memory. Sits between the control unit's decoded instruction fields and the datapath enables, and reports program start/finish to the top level.

## Interface
- MEM_LAT, 2: data-memory access latency in cycles, legal range 1..15.
- CNT_W, 16: width of the cycle counter.

- CLK  input  1  system clock, all state updates on rising edge.
- reset_ctrl  input  1  synchronous, active-high reset.
- start  input  1  launches program from PC 0; sampled only in IDLE or DONE.
- halt  input  1  decoded HALT opcode of the current instruction.
- is_load  input  1  current instruction reads data memory.
- is_store  input  1  current instruction writes data memory.
- wr_acc  input  1  current instruction writes the accumulator.
- wr_rf  input  1  current instruction writes the register file.
- pc_clr  output  1  clear PC to 0.
- pc_en  output  1  advance/branch PC at end of instruction.
- ir_load  output  1  latch instruction ROM output.
- acc_we  output  1  accumulator write enable.
- rf_we  output  1  register file write enable.
- mem_re  output  1  data memory read enable.
- mem_we  output  1  data memory write enable.
- busy  output  1  program running.
- done  output  1  program halted.
- cyc_cnt  output  CNT_W  cycles spent busy in the current run.

## Operation
- States: IDLE, FETCH, EXEC, MEM, DONE. One-hot or binary is implementer's choice; only the outputs below are observable.
- IDLE: busy=0, done=0. start=1 -> FETCH, pc_clr=1 this cycle.
- FETCH: ir_load=1 -> EXEC.
- EXEC (decode inputs valid, held stable by control unit until next ir_load):
  - halt=1 -> DONE; no strobes asserted, halt overrides all other decode inputs.
  - is_load or is_store -> MEM, wait counter loaded with MEM_LAT-1.
  - otherwise: acc_we=wr_acc, rf_we=wr_rf, pc_en=1 -> FETCH.
- MEM: mem_re=is_load, mem_we=is_store&~is_load (load wins if both set), held every MEM cycle. Counter decrements each cycle; when counter==0: acc_we=wr_acc&is_load, rf_we=wr_rf&is_load, pc_en=1 -> FETCH. MEM_LAT=1 means exactly one MEM cycle.
- DONE: done=1, busy=0, held indefinitely. start=1 -> FETCH with pc_clr=1 (relaunch).
- busy=1 in FETCH, EXEC, MEM.
- start while busy is ignored.
- Strobes are combinational from state register and decode inputs; no strobe asserted outside the states listed.

## Timing
- Reset: state=IDLE, wait counter=0, cyc_cnt=0; all outputs 0 in the cycle after reset is sampled. Reset mid-instruction aborts immediately; no strobe asserts after the reset edge.
- pc_clr asserted in the cycle start is sampled; first ir_load the next cycle.
- Non-memory instruction: 2 cycles (FETCH, EXEC).
- Memory instruction: 2+MEM_LAT cycles.
- HALT: 2 cycles, done rises on the cycle after EXEC.
- pc_en pulses exactly once per non-halt instruction, in its last cycle.

## Configuration
- EXEC_SEQ_CYCLE_CNT_EN defined: cyc_cnt clears to 0 on every accepted start, increments by 1 each cycle busy=1, saturates at 2^CNT_W-1, holds its value in DONE until next start.
- Not defined: counter logic omitted, cyc_cnt tied to 0.

## Test plan
- Reset, then start pulse with ALU instruction (wr_acc=1) followed by HALT -> pc_clr at cycle 0, ir_load cycles 1 and 3, acc_we+pc_en cycle 2, done=1 from cycle 5; cyc_cnt=4 (macro on).
- MEM_LAT=2, load with wr_rf=1 -> mem_re high 2 cycles, rf_we and pc_en only on the second; instruction spans 4 cycles.
- Store with wr_acc=1 -> mem_we high MEM_LAT cycles, acc_we never asserted; is_load=is_store=1 -> mem_re only, mem_we stays 0.
- halt=1 with is_store=1 in EXEC -> no mem_we, DONE next cycle; start during busy ignored (no pc_clr).
- reset_ctrl asserted in the middle of MEM -> next cycle all outputs 0, state IDLE, cyc_cnt=0; start then relaunches normally.
- CNT_W=4, 20-cycle program with macro on -> cyc_cnt saturates at 15; macro off -> cyc_cnt 0 throughout.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Decode-field and strobe bundle between the control unit and exec_sequencer.
// master: control unit side (drives start/decode, receives strobes).
// slave:  sequencer side.
interface exec_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             halt;
  logic             is_load;
  logic             is_store;
  logic             wr_acc;
  logic             wr_rf;
  logic             pc_clr;
  logic             pc_en;
  logic             ir_load;
  logic             acc_we;
  logic             rf_we;
  logic             mem_re;
  logic             mem_we;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cyc_cnt;

  modport master (
    output start, halt, is_load, is_store, wr_acc, wr_rf,
    input  pc_clr, pc_en, ir_load, acc_we, rf_we, mem_re, mem_we, busy, done, cyc_cnt
  );

  modport slave (
    input  start, halt, is_load, is_store, wr_acc, wr_rf,
    output pc_clr, pc_en, ir_load, acc_we, rf_we, mem_re, mem_we, busy, done, cyc_cnt
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH, EXEC and
// optional MEM phases and drives the datapath enable strobes.
// Optional busy-cycle counter enabled by defining EXEC_SEQ_CYCLE_CNT_EN;
// without it cyc_cnt is tied to 0.
module exec_sequencer #(
  parameter int unsigned MEM_LAT = 2,  // data-memory latency, 1..15
  parameter int unsigned CNT_W   = 16
) (
  input logic              CLK,
  input logic              reset_ctrl,
  exec_sequencer_if.slave  seq
);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StDone} state_e;

  localparam logic [3:0] MemLatM1 = 4'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic pc_clr, pc_en, ir_load, acc_we, rf_we, mem_re, mem_we, busy, done;

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset_ctrl) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and strobe decode from current state and decode inputs.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pc_clr  = 1'b0;
    pc_en   = 1'b0;
    ir_load = 1'b0;
    acc_we  = 1'b0;
    rf_we   = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (seq.start) begin
          pc_clr  = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: begin
        busy    = 1'b1;
        ir_load = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        busy = 1'b1;
        // HALT suppresses every other decode field.
        if (seq.halt) begin
          state_d = StDone;
        end else if (seq.is_load || seq.is_store) begin
          state_d = StMem;
          wait_d  = MemLatM1;
        end else begin
          acc_we  = seq.wr_acc;
          rf_we   = seq.wr_rf;
          pc_en   = 1'b1;
          state_d = StFetch;
        end
      end
      StMem: begin
        busy   = 1'b1;
        mem_re = seq.is_load;
        mem_we = seq.is_store & ~seq.is_load;  // load wins when both are set
        if (wait_q == 4'd0) begin
          acc_we  = seq.wr_acc & seq.is_load;
          rf_we   = seq.wr_rf & seq.is_load;
          pc_en   = 1'b1;
          state_d = StFetch;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StDone: begin
        done = 1'b1;
        if (seq.start) begin
          pc_clr  = 1'b1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign seq.pc_clr  = pc_clr;
  assign seq.pc_en   = pc_en;
  assign seq.ir_load = ir_load;
  assign seq.acc_we  = acc_we;
  assign seq.rf_we   = rf_we;
  assign seq.mem_re  = mem_re;
  assign seq.mem_we  = mem_we;
  assign seq.busy    = busy;
  assign seq.done    = done;

`ifdef EXEC_SEQ_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Busy-cycle counter: cleared on accepted start, saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (pc_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (busy && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset_ctrl) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign seq.cyc_cnt = cnt_q;
`else
  assign seq.cyc_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed table, hand sequences for
// reset/halt/saturation corners, and randomized programs against an
// instruction-level model that expands each instruction into its cycle list.
module tb_exec_sequencer;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // Output vector order: {pc_clr, pc_en, ir_load, acc_we, rf_we, mem_re, mem_we, busy, done}
  localparam logic [8:0] E_IDLE  = 9'b000000000;
  localparam logic [8:0] E_FETCH = 9'b001000010;
  localparam logic [8:0] E_BUSY  = 9'b000000010;
  localparam logic [8:0] E_DONE  = 9'b000000001;

  logic CLK = 1'b0;
  logic reset_ctrl;

  exec_sequencer_if #(.CNT_W(CNT_W)) bus ();

  exec_sequencer #(
    .MEM_LAT(MEM_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK       (CLK),
    .reset_ctrl(reset_ctrl),
    .seq       (bus)
  );

  always #5 CLK = ~CLK;

  logic [8:0] outs;
  assign outs = {bus.pc_clr, bus.pc_en, bus.ir_load, bus.acc_we, bus.rf_we,
                 bus.mem_re, bus.mem_we, bus.busy, bus.done};

  int ncmp  = 0;
  int nfail = 0;
  int busy_cyc = 0;   // busy cycles since the last accepted start
  bit in_done  = 0;

  typedef struct {
    bit h, ld, st, wa, wr;
    logic [8:0] e_exec;
    logic [8:0] e_mem;   // non-final MEM cycles
    logic [8:0] e_last;  // final MEM cycle
  } vec_t;

  vec_t tbl[8];

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef EXEC_SEQ_CYCLE_CNT_EN
    return (busy_cyc > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(busy_cyc);
`else
    return '0;
`endif
  endfunction

  task automatic check_cnt(input string nm, input logic [CNT_W-1:0] e);
    ncmp++;
    if (bus.cyc_cnt !== e) begin
      nfail++;
      $display("FAIL %s: cyc_cnt got %0d expected %0d", nm, bus.cyc_cnt, e);
    end
  endtask

  // One clock cycle: compare at negedge, then advance to just after posedge.
  task automatic step(input string nm, input logic [8:0] e);
    @(negedge CLK);
    ncmp++;
    if (outs !== e) begin
      nfail++;
      $display("FAIL %s: strobes got %b expected %b", nm, outs, e);
    end
    check_cnt(nm, exp_cnt());
    if (e[8]) busy_cyc = 0;
    else if (e[1]) busy_cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_dec(input bit h, ld, st, wa, wr);
    bus.halt = h; bus.is_load = ld; bus.is_store = st; bus.wr_acc = wa; bus.wr_rf = wr;
  endtask

  task automatic launch();
    bus.start = 1'b1;
    step("launch", {1'b1, 7'b0, in_done});
    bus.start = 1'b0;
    in_done = 0;
  endtask

  task automatic do_reset();
    reset_ctrl = 1'b1;
    @(posedge CLK);
    #1;
    reset_ctrl = 1'b0;
    busy_cyc = 0;
    in_done = 0;
  endtask

  // Reference model: one instruction expanded into its expected cycle list.
  task automatic run_instr(input bit h, ld, st, wa, wr, input bit rs);
    set_dec(h, ld, st, wa, wr);
    bus.start = rs ? ($urandom_range(0, 2) == 0) : 1'b0;
    step("fetch", E_FETCH);
    bus.start = rs ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (h) begin
      step("exec_halt", E_BUSY);
      in_done = 1;
    end else if (ld || st) begin
      step("exec_mem", E_BUSY);
      for (int i = 1; i <= MEM_LAT; i++) begin
        bit last;
        last = (i == MEM_LAT);
        bus.start = rs ? ($urandom_range(0, 2) == 0) : 1'b0;
        step("mem", {1'b0, last, 1'b0, last & wa & ld, last & wr & ld, ld, st & ~ld,
                     1'b1, 1'b0});
      end
    end else begin
      step("exec_alu", {1'b0, 1'b1, 1'b0, wa, wr, 2'b00, 1'b1, 1'b0});
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{0, 0, 0, 1, 0, 9'b010100010, 9'b0,         9'b0};
    tbl[1] = '{0, 0, 0, 0, 1, 9'b010010010, 9'b0,         9'b0};
    tbl[2] = '{0, 0, 0, 1, 1, 9'b010110010, 9'b0,         9'b0};
    tbl[3] = '{0, 0, 0, 0, 0, 9'b010000010, 9'b0,         9'b0};
    tbl[4] = '{0, 1, 0, 0, 1, E_BUSY,       9'b000001010, 9'b010011010};
    tbl[5] = '{0, 1, 0, 1, 0, E_BUSY,       9'b000001010, 9'b010101010};
    tbl[6] = '{0, 0, 1, 1, 0, E_BUSY,       9'b000000110, 9'b010000110};
    tbl[7] = '{0, 1, 1, 1, 1, E_BUSY,       9'b000001010, 9'b010111010};

    bus.start = 1'b0;
    set_dec(0, 0, 0, 0, 0);
    reset_ctrl = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    reset_ctrl = 1'b0;
    step("reset", E_IDLE);

    // ALU instruction then HALT.
    launch();
    run_instr(0, 0, 0, 1, 0, 0);
    run_instr(1, 0, 0, 0, 0, 0);
    @(negedge CLK);
`ifdef EXEC_SEQ_CYCLE_CNT_EN
    check_cnt("alu_halt_cnt", CNT_W'(4));
`else
    check_cnt("alu_halt_cnt", CNT_W'(0));
`endif
    @(posedge CLK);
    #1;
    step("done_hold", E_DONE);
    step("done_hold", E_DONE);

    // Table-driven instructions, relaunched from DONE.
    launch();
    for (int i = 0; i < 8; i++) begin
      set_dec(tbl[i].h, tbl[i].ld, tbl[i].st, tbl[i].wa, tbl[i].wr);
      step("tbl_fetch", E_FETCH);
      step("tbl_exec", tbl[i].e_exec);
      if (tbl[i].ld || tbl[i].st) begin
        step("tbl_mem", tbl[i].e_mem);
        step("tbl_last", tbl[i].e_last);
      end
    end

    // HALT with store set; start during busy ignored.
    set_dec(1, 0, 1, 1, 1);
    bus.start = 1'b1;
    step("halt_st_fetch", E_FETCH);
    step("halt_st_exec", E_BUSY);
    bus.start = 1'b0;
    in_done = 1;
    step("halt_st_done", E_DONE);

    // Reset in the middle of MEM.
    launch();
    set_dec(0, 1, 0, 1, 1);
    step("rst_fetch", E_FETCH);
    step("rst_exec", E_BUSY);
    step("rst_mem0", 9'b000001010);
    do_reset();
    step("rst_after", E_IDLE);
    step("rst_idle", E_IDLE);
    launch();
    run_instr(0, 1, 0, 0, 1, 0);
    run_instr(1, 0, 0, 0, 0, 0);

    // Long program for counter saturation.
    launch();
    for (int i = 0; i < 10; i++) run_instr(0, 0, 0, 1, 1, 0);
    run_instr(1, 0, 0, 0, 0, 0);
    @(negedge CLK);
`ifdef EXEC_SEQ_CYCLE_CNT_EN
    check_cnt("sat_cnt", CNT_W'(CNT_MAX));
`else
    check_cnt("sat_cnt", CNT_W'(0));
`endif
    @(posedge CLK);
    #1;

    // Randomized programs with stray start pulses while busy.
    for (int p = 0; p < 12; p++) begin
      int n;
      if ($urandom_range(0, 1) == 1) step("rnd_done_idle", E_DONE);
      launch();
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        run_instr(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
      end
      run_instr(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
      step("rnd_done", E_DONE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
